// File: rtl/piano_seq_pkg.sv
// Shared types and song-entry field layout for the piano melody sequencer.
// Used by piano_seq_ctrl (optional PIANO_SEQ_LOOP_EN build) and its testbench.
package piano_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  localparam logic [DUR_MSB-DUR_LSB:0] END_MARKER = 4'd0;

  function automatic logic [NOTE_MSB-NOTE_LSB:0] entry_note(input logic [7:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_MSB-DUR_LSB:0] entry_dur(input logic [7:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/piano_tick_gen.sv
// Clock prescaler: one-cycle tick every TICK_DIV cycles, restartable by clr.
// Shared by timing blocks that need a full first period after a restart.
module piano_tick_gen #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Combinational so the sequencer can act on the final cycle of a period.
  assign tick = (count == LAST);

endmodule

// File: rtl/piano_seq_ctrl.sv
// Melody sequencer: plays (note, duration) entries from a small song memory.
// Define PIANO_SEQ_LOOP_EN to repeat the song forever instead of pulsing done.
module piano_seq_ctrl
  import piano_seq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 2500000,
  parameter int GAP_TICKS = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  output logic [3:0]    note,
  output logic          hush,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr
);

  localparam int LW = 16;

  state_t        state, state_nxt;
  logic [3:0]    note_nxt;
  logic [AW-1:0] addr_nxt, addr_inc;
  logic [LW-1:0] ticks_left, ticks_left_nxt;
  logic          tick, tick_clr;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    first_entry, next_entry;
  logic          last_slot;

  state_t        fetch_state;
  logic [3:0]    fetch_note;
  logic [AW-1:0] fetch_addr;
  logic [LW-1:0] fetch_left;

  piano_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // NOTE: song memory has no reset; contents survive rst by design.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign addr_inc    = addr + AW'(1);
  assign first_entry = mem[0];
  assign next_entry  = mem[addr_inc];
  assign last_slot   = (addr == AW'(DEPTH - 1));

  // Outcome of advancing past the current entry, used at the end of PLAY or GAP.
  always_comb begin
    fetch_state = PLAY;
    fetch_note  = entry_note(next_entry);
    fetch_addr  = addr_inc;
    fetch_left  = LW'(entry_dur(next_entry));
    if (last_slot || entry_dur(next_entry) == END_MARKER) begin
`ifdef PIANO_SEQ_LOOP_EN
      fetch_addr = '0;
      fetch_note = entry_note(first_entry);
      fetch_left = LW'(entry_dur(first_entry));
      if (entry_dur(first_entry) == END_MARKER) begin
        fetch_state = IDLE;
        fetch_note  = note;
        fetch_left  = '0;
      end
`else
      fetch_state = DONE;
      fetch_addr  = '0;
      fetch_note  = note;
      fetch_left  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      note       <= '0;
      addr       <= '0;
      ticks_left <= '0;
    end else begin
      state      <= state_nxt;
      note       <= note_nxt;
      addr       <= addr_nxt;
      ticks_left <= ticks_left_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_nxt      = state;
    note_nxt       = note;
    addr_nxt       = addr;
    ticks_left_nxt = ticks_left;
    tick_clr       = 1'b0;
    unique case (state)
      IDLE: begin
        tick_clr = 1'b1;
        if (start) begin
          addr_nxt = '0;
          if (entry_dur(first_entry) == END_MARKER) begin
            state_nxt = DONE;
          end else begin
            state_nxt      = PLAY;
            note_nxt       = entry_note(first_entry);
            ticks_left_nxt = LW'(entry_dur(first_entry));
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (ticks_left == LW'(1)) begin
            tick_clr = 1'b1;
            if (GAP_TICKS > 0) begin
              state_nxt      = GAP;
              ticks_left_nxt = LW'(GAP_TICKS);
            end else begin
              state_nxt      = fetch_state;
              note_nxt       = fetch_note;
              addr_nxt       = fetch_addr;
              ticks_left_nxt = fetch_left;
            end
          end else begin
            ticks_left_nxt = ticks_left - LW'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (ticks_left == LW'(1)) begin
            tick_clr       = 1'b1;
            state_nxt      = fetch_state;
            note_nxt       = fetch_note;
            addr_nxt       = fetch_addr;
            ticks_left_nxt = fetch_left;
          end else begin
            ticks_left_nxt = ticks_left - LW'(1);
          end
        end
      end
      DONE: begin
        tick_clr  = 1'b1;
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (stop) begin
      state_nxt      = IDLE;
      addr_nxt       = '0;
      ticks_left_nxt = '0;
      tick_clr       = 1'b1;
    end
  end

  assign hush = (state != PLAY);
  assign busy = (state == PLAY) || (state == GAP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_piano_seq_ctrl.sv
// Scoreboard testbench for piano_seq_ctrl (TICK_DIV=4, GAP_TICKS=1, DEPTH=16).
// Expected per-cycle outputs are queued at stimulus time and compared at negedge.
module tb_piano_seq_ctrl;

  localparam int DEPTH     = 16;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int AW        = 4;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, stop;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [3:0]    note;
  logic          hush, busy, done;
  logic [AW-1:0] addr;

  always #5 clk = ~clk;

  piano_seq_ctrl #(
    .DEPTH     (DEPTH),
    .TICK_DIV  (TICK_DIV),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .stop    (stop),
    .note    (note),
    .hush    (hush),
    .busy    (busy),
    .done    (done),
    .addr    (addr)
  );

  typedef struct {
    string         tag;
    logic [3:0]    note;
    bit            chk_note;
    logic          hush;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] tb_mem [DEPTH];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".hush"}, 32'(hush), 32'(mon_e.hush));
      check({mon_e.tag, ".busy"}, 32'(busy), 32'(mon_e.busy));
      check({mon_e.tag, ".done"}, 32'(done), 32'(mon_e.done));
      check({mon_e.tag, ".addr"}, 32'(addr), 32'(mon_e.addr));
      if (mon_e.chk_note) check({mon_e.tag, ".note"}, 32'(note), 32'(mon_e.note));
    end
  end

  task automatic push(input string tag, input logic [3:0] n, input bit cn, input logic h,
                      input logic b, input logic d, input logic [AW-1:0] a, input int cnt);
    exp_t e;
    e.tag = tag; e.note = n; e.chk_note = cn; e.hush = h; e.busy = b; e.done = d; e.addr = a;
    for (int k = 0; k < cnt; k++) sb.push_back(e);
  endtask

  // Schedule of a normal (non-looping) playback of tb_mem, starting with the start cycle.
  task automatic expect_song(input string tag);
    int i;
    push({tag, ".c0"}, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1);
    i = 0;
    while (i < DEPTH && tb_mem[i][3:0] != 4'd0) begin
      push({tag, ".play"}, tb_mem[i][7:4], 1'b1, 1'b0, 1'b1, 1'b0, AW'(i),
           int'(tb_mem[i][3:0]) * TICK_DIV);
      push({tag, ".gap"}, tb_mem[i][7:4], 1'b1, 1'b1, 1'b1, 1'b0, AW'(i), GAP_TICKS * TICK_DIV);
      i++;
    end
    push({tag, ".done"}, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, '0, 1);
    push({tag, ".idle"}, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1);
  endtask

  task automatic write_entry(input int a, input logic [3:0] n, input logic [3:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {n, d};
    tb_mem[a] = {n, d};
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic kick(input logic s, input logic p);
    @(posedge clk); #1;
    start = s; stop = p;
  endtask

  task automatic release_ctl();
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check({tag, ".timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.note", 32'(note), 32'h0);
    check("reset.hush", 32'(hush), 32'h1);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.done", 32'(done), 32'h0);
    check("reset.addr", 32'(addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef PIANO_SEQ_LOOP_EN
    write_entry(0, 4'h3, 4'd1);
    write_entry(1, 4'h0, 4'd0);
    kick(1'b1, 1'b0);
    push("loop.c0", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1);
    for (int r = 0; r < 3; r++) begin
      push("loop.play", 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, '0, TICK_DIV);
      push("loop.gap", 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, '0, TICK_DIV);
    end
    release_ctl();
    repeat (23) @(posedge clk);
    #1;
    stop = 1'b1;
    push("loop.stopped", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 2);
    @(posedge clk); #1;
    stop = 1'b0;
    drain("loop", 100);
`else
    // Basic two-note song.
    write_entry(0, 4'h0, 4'd2);
    write_entry(1, 4'hC, 4'd1);
    write_entry(2, 4'h0, 4'd0);
    kick(1'b1, 1'b0);
    expect_song("basic");
    release_ctl();
    drain("basic", 100);

    // Empty song: immediate done, never busy.
    write_entry(0, 4'h5, 4'd0);
    kick(1'b1, 1'b0);
    expect_song("empty");
    release_ctl();
    drain("empty", 20);

    // Abort during the first note.
    write_entry(0, 4'h7, 4'd3);
    write_entry(1, 4'h0, 4'd0);
    kick(1'b1, 1'b0);
    push("abort.c0", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1);
    push("abort.play", 4'h7, 1'b1, 1'b0, 1'b1, 1'b0, '0, 5);
    push("abort.idle", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 3);
    release_ctl();
    repeat (4) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    drain("abort", 40);

    // start together with stop from IDLE stays idle.
    kick(1'b1, 1'b1);
    push("startstop", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 4);
    release_ctl();
    drain("startstop", 20);

    // Write and restart attempts during PLAY are ignored.
    write_entry(0, 4'h9, 4'd2);
    write_entry(1, 4'h0, 4'd0);
    kick(1'b1, 1'b0);
    expect_song("lockout");
    release_ctl();
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 8'hA3; start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    drain("lockout", 100);

    // Full memory: song ends on address wrap.
    for (int i = 0; i < DEPTH; i++) write_entry(i, 4'(i), 4'd1);
    kick(1'b1, 1'b0);
    expect_song("wrap");
    release_ctl();
    drain("wrap", 400);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
